// File: rtl/ctrl_teclado_pkg.sv
// Shared constants and state encodings for the 4x4 keypad controller.
package ctrl_teclado_pkg;

   localparam logic [4:0] KEY_NONE  = 5'h10;
   localparam logic [4:0] KEY_MULTI = 5'h11;
   localparam logic [4:0] KEY_STAR  = 5'h0E;
   localparam logic [4:0] KEY_HASH  = 5'h0F;

   typedef enum logic [1:0] {
      DB_IDLE,
      DB_CAND,
      DB_PRESSED,
      DB_REL_CAND
   } db_state_e;

   typedef enum logic {
      EN_EDIT,
      EN_DONE
   } en_state_e;

   // Fold one column's code into the running scan result
   function automatic logic [4:0] merge_code(logic [4:0] acc,
                                             logic [4:0] cur);
      if (cur == KEY_NONE) return acc;
      if (acc == KEY_NONE) return cur;
      return KEY_MULTI;
   endfunction

endpackage

// File: rtl/ctrl_teclado_if.sv
// Keypad lines and entry results between the controller and its user.
interface ctrl_teclado_if #(
   parameter int NDIG = 4
);
   localparam int LW = $clog2(NDIG + 1);

   logic [3:0]        fila;
   logic [3:0]        col;
   logic [4:0]        key_code;
   logic              key_valid;
   logic [4*NDIG-1:0] entry_value;
   logic [LW-1:0]     entry_len;
   logic              entry_done;
   logic              entry_err;

   modport master (
      output fila,
      input  col, key_code, key_valid,
      input  entry_value, entry_len, entry_done, entry_err
   );

   modport slave (
      input  fila,
      output col, key_code, key_valid,
      output entry_value, entry_len, entry_done, entry_err
   );

endinterface

// File: rtl/ctrl_teclado_dec_tecla.sv
// Maps the active column and its sampled rows to a key code.
module dec_tecla
   import ctrl_teclado_pkg::*;
(
   input  logic [3:0] col,
   input  logic [3:0] fila,
   output logic [4:0] code
);

   logic [1:0] ci;
   logic [1:0] ri;
   logic       hit;

   always_comb begin
      ci   = 2'd0;
      ri   = 2'd0;
      hit  = 1'b1;
      code = KEY_NONE;
      unique case (1'b1)
         col[0]:  ci = 2'd0;
         col[1]:  ci = 2'd1;
         col[2]:  ci = 2'd2;
         col[3]:  ci = 2'd3;
         default: ci = 2'd0;
      endcase
      case (fila)
         4'b0000: begin hit = 1'b0; code = KEY_NONE; end
         4'b0001: ri = 2'd0;
         4'b0010: ri = 2'd1;
         4'b0100: ri = 2'd2;
         4'b1000: ri = 2'd3;
         default: begin hit = 1'b0; code = KEY_MULTI; end
      endcase
      // Columns 0-2 hold the phone-style digit grid
      if (hit) begin
         if (ci == 2'd3) begin
            code = 5'hA + {3'b0, ri};
         end else if (ri == 2'd3) begin
            case (ci)
               2'd0:    code = KEY_HASH;
               2'd1:    code = 5'h0;
               default: code = KEY_STAR;
            endcase
         end else begin
            code = {3'b0, ri} + {3'b0, ri} + {3'b0, ri}
                 + {3'b0, ci} + 5'd1;
         end
      end
   end

endmodule

// File: rtl/ctrl_teclado.sv
// Keypad column scanner, debouncer and BCD entry assembler.
module ctrl_teclado
   import ctrl_teclado_pkg::*;
#(
   parameter int SETTLE_CYC = 4,
   parameter int DEBOUNCE   = 3,
   parameter int NDIG       = 4
) (
   input logic           clk,
   input logic           rst_n,
   ctrl_teclado_if.slave bus
);

   localparam int SW = $clog2(SETTLE_CYC);
   localparam int CW = $clog2(DEBOUNCE + 1);
   localparam int VW = 4 * NDIG;
   localparam int LW = $clog2(NDIG + 1);

   logic [3:0]    fila_s1_q, fila_s2_q;
   logic [SW-1:0] set_q;
   logic [3:0]    col_q;
   logic [4:0]    acc_q;
   db_state_e     db_q;
   logic [CW-1:0] cnt_q;
   logic [4:0]    cand_q;
   logic [4:0]    key_code_q;
   logic          kv_q;
   en_state_e     en_q;
   logic [VW-1:0] val_q;
   logic [LW-1:0] len_q;
   logic          done_q, err_q;

   logic [4:0]    col_code;
   logic [4:0]    scan_d;
   logic [CW-1:0] cnt_d;
   logic          hold_end, scan_end, is_key, is_none, cnt_hit;
   logic          is_digit, is_star, is_hash;

   dec_tecla u_dec (
      .col  (col_q),
      .fila (fila_s2_q),
      .code (col_code)
   );

   assign hold_end = (set_q == SW'(SETTLE_CYC - 1));
   assign scan_end = hold_end & col_q[3];
   assign scan_d   = merge_code(acc_q, col_code);
   assign is_none  = (scan_d == KEY_NONE);
   assign is_key   = !is_none && (scan_d != KEY_MULTI);
   assign cnt_d    = cnt_q + CW'(1);
   assign cnt_hit  = (cnt_d == CW'(DEBOUNCE));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fila_s1_q <= '0;
         fila_s2_q <= '0;
         set_q     <= '0;
         col_q     <= 4'b0001;
         acc_q     <= KEY_NONE;
      end else begin
         fila_s1_q <= bus.fila;
         fila_s2_q <= fila_s1_q;
         if (hold_end) begin
            set_q <= '0;
            col_q <= {col_q[2:0], col_q[3]};
            acc_q <= scan_end ? KEY_NONE : scan_d;
         end else begin
            set_q <= set_q + SW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         db_q       <= DB_IDLE;
         cnt_q      <= '0;
         cand_q     <= KEY_NONE;
         key_code_q <= KEY_NONE;
         kv_q       <= 1'b0;
      end else begin
         kv_q <= 1'b0;
         if (scan_end) begin
            unique case (db_q)
               DB_IDLE: if (is_key) begin
                  cand_q <= scan_d;
                  cnt_q  <= CW'(1);
                  if (DEBOUNCE == 1) begin
                     db_q       <= DB_PRESSED;
                     kv_q       <= 1'b1;
                     key_code_q <= scan_d;
                  end else begin
                     db_q <= DB_CAND;
                  end
               end
               DB_CAND: begin
                  if (!is_key) begin
                     db_q <= DB_IDLE;
                  end else if (scan_d != cand_q) begin
                     cand_q <= scan_d;
                     cnt_q  <= CW'(1);
                  end else if (cnt_hit) begin
                     db_q       <= DB_PRESSED;
                     kv_q       <= 1'b1;
                     key_code_q <= cand_q;
                  end else begin
                     cnt_q <= cnt_d;
                  end
               end
               DB_PRESSED: if (is_none) begin
                  cnt_q <= CW'(1);
                  db_q  <= (DEBOUNCE == 1) ? DB_IDLE : DB_REL_CAND;
               end
               DB_REL_CAND: begin
                  if (!is_none) db_q <= DB_PRESSED;
                  else if (cnt_hit) db_q <= DB_IDLE;
                  else cnt_q <= cnt_d;
               end
               default: db_q <= DB_IDLE;
            endcase
         end
      end
   end

   assign is_digit = (key_code_q < 5'd10);
   assign is_star  = (key_code_q == KEY_STAR);
   assign is_hash  = (key_code_q == KEY_HASH);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en_q   <= EN_EDIT;
         val_q  <= '0;
         len_q  <= '0;
         done_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         if (kv_q) begin
            unique case (1'b1)
               is_digit: begin
                  if (en_q == EN_DONE) begin
                     val_q <= VW'(key_code_q[3:0]);
                     len_q <= LW'(1);
                     en_q  <= EN_EDIT;
                  end else if (len_q < LW'(NDIG)) begin
                     val_q <= (val_q << 4) | VW'(key_code_q[3:0]);
                     len_q <= len_q + LW'(1);
                  end else begin
                     err_q <= 1'b1;
                  end
               end
               is_star: begin
                  val_q <= '0;
                  len_q <= '0;
                  en_q  <= EN_EDIT;
               end
               is_hash: begin
                  if (en_q == EN_EDIT && len_q != '0) begin
                     done_q <= 1'b1;
                     en_q   <= EN_DONE;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.col         = col_q;
   assign bus.key_code    = key_code_q;
   assign bus.key_valid   = kv_q;
   assign bus.entry_value = val_q;
   assign bus.entry_len   = len_q;
   assign bus.entry_done  = done_q;
   assign bus.entry_err   = err_q;

endmodule

// File: tb/tb_ctrl_teclado.sv
// Directed bench for ctrl_teclado: keypad model, vector table, corner sequences.
module tb_ctrl_teclado;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [15:0] mask = '0;
   logic [3:0] fila_m;

   int checks = 0;
   int errors = 0;
   int tot_val = 0, tot_done = 0, tot_err = 0, tot_both = 0;
   int b_val, b_done, b_err;

   always #5 clk = ~clk;

   ctrl_teclado_if #(.NDIG(4)) kbd ();

   ctrl_teclado #(
      .SETTLE_CYC (4),
      .DEBOUNCE   (3),
      .NDIG       (4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (kbd.slave)
   );

   // Pressed switches connect the driven column to their row
   always_comb begin
      fila_m = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            if (kbd.col[c] && mask[c*4+r]) fila_m[r] = 1'b1;
   end
   assign kbd.fila = fila_m;

   always @(negedge clk) begin
      if (rst_n) begin
         if (kbd.key_valid) tot_val = tot_val + 1;
         if (kbd.entry_done) tot_done = tot_done + 1;
         if (kbd.entry_err) tot_err = tot_err + 1;
         if (kbd.entry_done && kbd.entry_err) tot_both = tot_both + 1;
      end
   end

   function automatic logic [15:0] km(input logic [4:0] k);
      int idx;
      case (k)
         5'h1: idx = 0;  5'h4: idx = 1;  5'h7: idx = 2;  5'hF: idx = 3;
         5'h2: idx = 4;  5'h5: idx = 5;  5'h8: idx = 6;  5'h0: idx = 7;
         5'h3: idx = 8;  5'h6: idx = 9;  5'h9: idx = 10; 5'hE: idx = 11;
         5'hA: idx = 12; 5'hB: idx = 13; 5'hC: idx = 14; default: idx = 15;
      endcase
      return 16'(1) << idx;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic next_scan();
      int n;
      n = 0;
      while (kbd.col !== 4'b1000 && n < 200) begin
         @(negedge clk);
         n++;
      end
      while (kbd.col !== 4'b0001 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         checks++;
         errors++;
         $display("FAIL scan_timeout: col=%b after %0d cycles", kbd.col, n);
      end
   endtask

   task automatic scans(input logic [15:0] m, input int n);
      mask = m;
      repeat (n) next_scan();
   endtask

   task automatic base();
      #1;
      b_val = tot_val;
      b_done = tot_done;
      b_err = tot_err;
   endtask

   typedef struct {
      string       nm;
      logic [15:0] m;
      int          hold;
      int          nval;
      logic [4:0]  code;
      logic [15:0] val;
      int          len;
      int          ndone;
      int          nerr;
   } vec_t;

   vec_t vt [15];

   initial begin
      vt[0]  = '{"k5",      km(5'h5), 4, 1, 5'h5, 16'h0005, 1, 0, 0};
      vt[1]  = '{"star",    km(5'hE), 4, 1, 5'hE, 16'h0000, 0, 0, 0};
      vt[2]  = '{"d1",      km(5'h1), 4, 1, 5'h1, 16'h0001, 1, 0, 0};
      vt[3]  = '{"d2",      km(5'h2), 4, 1, 5'h2, 16'h0012, 2, 0, 0};
      vt[4]  = '{"d3",      km(5'h3), 4, 1, 5'h3, 16'h0123, 3, 0, 0};
      vt[5]  = '{"d4",      km(5'h4), 4, 1, 5'h4, 16'h1234, 4, 0, 0};
      vt[6]  = '{"d5_full", km(5'h5), 4, 1, 5'h5, 16'h1234, 4, 0, 1};
      vt[7]  = '{"hash",    km(5'hF), 4, 1, 5'hF, 16'h1234, 4, 1, 0};
      vt[8]  = '{"d7_new",  km(5'h7), 4, 1, 5'h7, 16'h0007, 1, 0, 0};
      vt[9]  = '{"star2",   km(5'hE), 4, 1, 5'hE, 16'h0000, 0, 0, 0};
      vt[10] = '{"hash_mt", km(5'hF), 4, 1, 5'hF, 16'h0000, 0, 0, 1};
      vt[11] = '{"d9",      km(5'h9), 4, 1, 5'h9, 16'h0009, 1, 0, 0};
      vt[12] = '{"star3",   km(5'hE), 4, 1, 5'hE, 16'h0000, 0, 0, 0};
      vt[13] = '{"keyA",    km(5'hA), 4, 1, 5'hA, 16'h0000, 0, 0, 0};
      vt[14] = '{"multi12", km(5'h1) | km(5'h2), 6, 0, 5'hA,
                 16'h0000, 0, 0, 0};

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_col", kbd.col, 4'b0001);
      chk("rst_code", kbd.key_code, 5'h10);
      chk("rst_kv", kbd.key_valid, 0);
      chk("rst_val", kbd.entry_value, 0);
      chk("rst_len", kbd.entry_len, 0);
      chk("rst_pulses", {kbd.entry_done, kbd.entry_err}, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_kv", kbd.key_valid, 0);
      repeat (2) @(negedge clk);
      chk("col_hold0", kbd.col, 4'b0001);
      @(negedge clk);
      chk("col_step1", kbd.col, 4'b0010);
      repeat (3) @(negedge clk);
      chk("col_hold1", kbd.col, 4'b0010);
      @(negedge clk);
      chk("col_step2", kbd.col, 4'b0100);
      next_scan();

      for (int i = 0; i < 15; i++) begin
         base();
         scans(vt[i].m, vt[i].hold);
         scans('0, 4);
         @(negedge clk);
         #1;
         chk({vt[i].nm, "_nval"}, tot_val - b_val, vt[i].nval);
         chk({vt[i].nm, "_code"}, kbd.key_code, vt[i].code);
         chk({vt[i].nm, "_val"}, kbd.entry_value, vt[i].val);
         chk({vt[i].nm, "_len"}, kbd.entry_len, vt[i].len);
         chk({vt[i].nm, "_done"}, tot_done - b_done, vt[i].ndone);
         chk({vt[i].nm, "_err"}, tot_err - b_err, vt[i].nerr);
      end

      // Pulse lands in the first cycle after the 3rd accepting scan
      next_scan();
      base();
      scans(km(5'h5), 2);
      #1;
      chk("t5_early", tot_val - b_val, 0);
      next_scan();
      chk("t5_pulse", kbd.key_valid, 1);
      chk("t5_code", kbd.key_code, 5'h5);
      @(negedge clk);
      chk("t5_one_cyc", kbd.key_valid, 0);
      next_scan();
      scans(km(5'h5), 2);
      scans('0, 4);
      #1;
      chk("t5_once", tot_val - b_val, 1);
      chk("t5_entry", kbd.entry_value, 16'h0005);

      // Bounce, then a 2-scan gap while held
      base();
      scans(km(5'h5), 2);
      scans('0, 1);
      scans(km(5'h5), 2);
      #1;
      chk("bnc_early", tot_val - b_val, 0);
      next_scan();
      chk("bnc_pulse", kbd.key_valid, 1);
      scans(km(5'h5), 2);
      scans('0, 2);
      scans(km(5'h5), 3);
      scans('0, 4);
      #1;
      chk("bnc_once", tot_val - b_val, 1);
      chk("bnc_entry", kbd.entry_value, 16'h0055);

      // Two keys held, then one released
      base();
      scans(km(5'h1) | km(5'h2), 3);
      scans(km(5'h1), 2);
      #1;
      chk("mk_none", tot_val - b_val, 0);
      next_scan();
      chk("mk_pulse", kbd.key_valid, 1);
      chk("mk_code", kbd.key_code, 5'h1);
      scans('0, 4);
      #1;
      chk("mk_once", tot_val - b_val, 1);
      chk("mk_len", kbd.entry_len, 3);

      // Reset mid-scan during a pending press
      scans(km(5'h8), 2);
      repeat (6) @(negedge clk);
      rst_n = 1'b0;
      mask = '0;
      #1;
      chk("mr_col", kbd.col, 4'b0001);
      chk("mr_code", kbd.key_code, 5'h10);
      chk("mr_val", kbd.entry_value, 0);
      chk("mr_len", kbd.entry_len, 0);
      chk("mr_pulses", {kbd.key_valid, kbd.entry_done, kbd.entry_err}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      base();
      scans('0, 4);
      #1;
      chk("mr_quiet", tot_val - b_val, 0);
      chk("never_both", tot_both, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
